// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative 32-cycle multiply/divide unit owning the HI/LO registers
module muldiv_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  // Count value seen on the 31st RUN edge; the 32nd step happens in FINISH.
  localparam logic [4:0] LAST_RUN_COUNT = 5'd30;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0]  count;
  logic [31:0] acc_hi;    // partial product high half / running remainder
  logic [31:0] acc_lo;    // multiplier bits being consumed / dividend shifting into quotient
  logic [31:0] opnd_b;    // magnitude of B: addend or divisor
  logic [31:0] a_raw;     // raw A bits, returned in HI on divide by zero
  logic        is_div;
  logic        neg_q;     // negate product (mul) or quotient (div)
  logic        neg_r;     // negate remainder (signed divide with negative dividend)

  logic        idle;
  logic        accept_md;
  logic        accept_mthi;
  logic        accept_mtlo;
  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        b_zero;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  // Request decode; a request is only honoured while the unit is idle.
  always_comb begin
    idle        = (state == S_IDLE);
    accept_md   = start && idle &&
                  ((op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU));
    accept_mthi = start && idle && (op == OP_MTHI);
    accept_mtlo = start && idle && (op == OP_MTLO);
    signed_op   = (op == OP_MULT) || (op == OP_DIV);
    mag_a       = (signed_op && A[31]) ? (32'd0 - A) : A;
    mag_b       = (signed_op && B[31]) ? (32'd0 - B) : B;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    fits    = (shifted >= {1'b0, opnd_b});
    diff    = shifted[31:0] - opnd_b;
    if (is_div) begin
      step_hi = fits ? diff : shifted[31:0];
      step_lo = {acc_lo[30:0], fits};
    end else begin
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo[31:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied to the final step.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? (64'd0 - prod) : prod;
    quo_fix  = neg_q ? (32'd0 - step_lo) : step_lo;
    rem_fix  = neg_r ? (32'd0 - step_hi) : step_hi;
    b_zero   = (opnd_b == 32'd0);
    if (!is_div) begin
      fin_hi = prod_fix[63:32];
      fin_lo = prod_fix[31:0];
    end else if (b_zero) begin
      fin_hi = a_raw;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN (31 steps) -> FINISH (last step + write) -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept_md) state_next = S_RUN;
      S_RUN:    if (count == LAST_RUN_COUNT) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers RUN and FINISH, decoded straight from the state flops.
  always_comb begin
    busy = (state == S_RUN) || (state == S_FINISH);
  end

  // Datapath, HI/LO and result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
      div0   <= 1'b0;
      count  <= 5'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      opnd_b <= 32'd0;
      a_raw  <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      if (accept_md) begin
        acc_hi <= 32'd0;
        acc_lo <= mag_a;
        opnd_b <= mag_b;
        a_raw  <= A;
        is_div <= (op == OP_DIV) || (op == OP_DIVU);
        neg_q  <= signed_op && (A[31] ^ B[31]);
        neg_r  <= (op == OP_DIV) && A[31];
        count  <= 5'd0;
      end else if (state == S_RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        count  <= count + 5'd1;
      end else if (state == S_FINISH) begin
        hi   <= fin_hi;
        lo   <= fin_lo;
        done <= 1'b1;
        div0 <= is_div && b_zero;
      end else if (accept_mthi) begin
        hi <= A;
      end else if (accept_mtlo) begin
        lo <= A;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - randomized self-checking bench for muldiv_hilo against an arithmetic model
module tb_muldiv_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int vectors;
  int miscompares;
  bit check_en;

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done, m_div0;
  logic [31:0] r_hi, r_lo;
  logic        r_div0;
  int          left;

  muldiv_hilo dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of a mul/div as {hi, lo}, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    logic [63:0]     res;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = 64'd0;
    case (o)
      3'd1: begin
        sq  = sx * sy;
        res = sq;
      end
      3'd2: res = ux * uy;
      3'd3: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          sq  = sx / sy;
          sr  = sx % sy;
          res = {sr[31:0], sq[31:0]};
        end
      end
      3'd4: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Transaction-level model: accept, count down 32 busy cycles, then publish.
  always @(posedge clk) begin
    logic [63:0] rr;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_div0 = 0; left = 0;
    end else begin
      m_done = 0;
      m_div0 = 0;
      if (m_busy) begin
        left = left - 1;
        if (left == 0) begin
          m_busy = 0;
          m_hi   = r_hi;
          m_lo   = r_lo;
          m_done = 1;
          m_div0 = r_div0;
        end
      end else if (start) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          rr     = ref_result(op, a, b);
          r_hi   = rr[63:32];
          r_lo   = rr[31:0];
          r_div0 = (op >= 3'd3) && (b == 32'd0);
          m_busy = 1;
          left   = 32;
        end else if (op == 3'd5) m_hi = a;
        else if (op == 3'd6) m_lo = a;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (hi !== m_hi || lo !== m_lo || busy !== m_busy || done !== m_done || div0 !== m_div0) begin
        miscompares++;
        $display("FAIL outputs t=%0t: hi=%h lo=%h busy=%b done=%b div0=%b required hi=%h lo=%h busy=%b done=%b div0=%b",
                 $time, hi, lo, busy, done, div0, m_hi, m_lo, m_busy, m_done, m_div0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Present a request for one edge; returns #1 after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
  endtask

  // Counts busy cycles, bounded; returns in the cycle where busy has dropped.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    if (cnt >= 40) begin
      miscompares++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, cnt);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_div0);
    int cnt;
    issue(o, x, y);
    wait_idle(cnt);
    check({name, "_busy_cycles"}, cnt, 32);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_div0"}, {31'd0, div0}, {31'd0, exp_div0});
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int cnt;
    int dones;
    vectors = 0; miscompares = 0; check_en = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_flags", {29'd0, busy, done, div0}, 32'd0);

    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFC, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b0);
    run_op("mult_pos", 3'd1, 32'd4, 32'd8, 32'd0, 32'h20, 1'b0);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", 3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_no_done", {30'd0, busy, done}, 32'd0);

    issue(3'd2, 32'd3, 32'd5);
    repeat (3) begin @(posedge clk); #1; end
    issue(3'd6, 32'd1, 32'd0);
    wait_idle(cnt);
    check("mtlo_ignored_lo", lo, 32'd15);
    check("mtlo_ignored_hi", hi, 32'd0);

    issue(3'd1, 32'h0001_2345, 32'hFFFF_0003);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midreset_no_done", dones, 0);

    // Random traffic: requests of every op, including during busy and in the done cycle.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      sel   = $urandom_range(0, 7);
      case (sel)
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (done && ($urandom_range(0, 1) == 0)) begin
        start = 1'b1;
        op = 3'($urandom_range(1, 4));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
